// File: rtl/snake_body_renderer.sv
// Snake body renderer: keeps a circular history of head positions, draws each new
// head pixel, erases the oldest pixel once at full length, and flags self-collision.
module snake_body_renderer #(
  parameter int          MAX_LEN     = 8,
  parameter int          INIT_LEN    = 4,
  parameter logic [2:0]  BODY_COLOUR = 3'b010,
  parameter logic [2:0]  BG_COLOUR   = 3'b000
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             step,
  input  logic [7:0]                       head_x,
  input  logic [6:0]                       head_y,
  input  logic                             grow,
  output logic [7:0]                       vga_x,
  output logic [6:0]                       vga_y,
  output logic [2:0]                       vga_colour,
  output logic                             vga_plot,
  output logic                             busy,
  output logic                             self_hit,
  output logic [$clog2(MAX_LEN+1)-1:0]     length
);

  localparam int PTR_W = $clog2(MAX_LEN);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {IDLE, ERASE, SCAN, DRAW} state_t;

  state_t             state;
  logic [7:0]         hx;
  logic [6:0]         hy;
  logic [14:0]        mem [MAX_LEN];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   scan_ptr;
  logic [LEN_W-1:0]   count;
  logic [LEN_W-1:0]   scan_left;

  assign busy = (state != IDLE);

  // NOTE: history storage carries no reset; count/pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (resetn && state == DRAW)
      mem[wr_ptr] <= {hx, hy};
  end

  // NOTE: all state below uses non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      hx         <= '0;
      hy         <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      scan_ptr   <= '0;
      count      <= '0;
      scan_left  <= '0;
      length     <= LEN_W'(INIT_LEN);
      self_hit   <= 1'b0;
      vga_plot   <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
    end else begin
      // Growth is independent of the step sequence; the erase decision below sees the old length.
      if (grow && length != LEN_W'(MAX_LEN))
        length <= length + LEN_W'(1);

      case (state)
        IDLE: begin
          vga_plot <= 1'b0;
          if (step) begin
            hx <= head_x;
            hy <= head_y;
            if (count == length) begin
              state            <= ERASE;
              vga_plot         <= 1'b1;
              {vga_x, vga_y}   <= mem[rd_ptr];
              vga_colour       <= BG_COLOUR;
            end else if (count != '0) begin
              state     <= SCAN;
              scan_ptr  <= rd_ptr;
              scan_left <= count;
            end else begin
              state      <= DRAW;
              vga_plot   <= 1'b1;
              vga_x      <= head_x;
              vga_y      <= head_y;
              vga_colour <= BODY_COLOUR;
            end
          end
        end

        ERASE: begin
          rd_ptr <= rd_ptr + PTR_W'(1);
          count  <= count - LEN_W'(1);
          if (count > LEN_W'(1)) begin
            state     <= SCAN;
            vga_plot  <= 1'b0;
            scan_ptr  <= rd_ptr + PTR_W'(1);
            scan_left <= count - LEN_W'(1);
          end else begin
            state      <= DRAW;
            vga_plot   <= 1'b1;
            vga_x      <= hx;
            vga_y      <= hy;
            vga_colour <= BODY_COLOUR;
          end
        end

        SCAN: begin
          if (mem[scan_ptr] == {hx, hy})
            self_hit <= 1'b1;
          scan_ptr  <= scan_ptr + PTR_W'(1);
          scan_left <= scan_left - LEN_W'(1);
          if (scan_left == LEN_W'(1)) begin
            state      <= DRAW;
            vga_plot   <= 1'b1;
            vga_x      <= hx;
            vga_y      <= hy;
            vga_colour <= BODY_COLOUR;
          end
        end

        DRAW: begin
          wr_ptr   <= wr_ptr + PTR_W'(1);
          count    <= count + LEN_W'(1);
          vga_plot <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          state    <= IDLE;
          vga_plot <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snake_body_renderer.sv
// Bench for snake_body_renderer: a queue-based model of the snake predicts every output
// each cycle; directed scenarios pin the model with literal plot sequences.
module tb_snake_body_renderer;

  localparam int         MAX_LEN  = 8;
  localparam int         INIT_LEN = 4;
  localparam logic [2:0] BODY     = 3'b010;
  localparam logic [2:0] BG       = 3'b000;

  logic       clk = 1'b0;
  logic       resetn, step, grow;
  logic [7:0] head_x;
  logic [6:0] head_y;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot, busy, self_hit;
  logic [3:0] length;

  snake_body_renderer #(
    .MAX_LEN(MAX_LEN), .INIT_LEN(INIT_LEN), .BODY_COLOUR(BODY), .BG_COLOUR(BG)
  ) dut (
    .clk(clk), .resetn(resetn), .step(step), .head_x(head_x), .head_y(head_y),
    .grow(grow), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .busy(busy), .self_hit(self_hit), .length(length)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs for one cycle.
  typedef struct {
    bit       plot;
    bit [7:0] x;
    bit [6:0] y;
    bit [2:0] c;
    bit       busy;
    bit       hit;
    int       len;
  } exp_t;

  exp_t        cur;
  exp_t        sched[$];
  bit   [14:0] body[$];
  int          mlen;
  bit          mhit;
  bit          model_valid = 1'b0;

  // A step turns into a list of per-cycle outputs: optional erase, one idle cycle per
  // remaining body segment, then the head draw.
  task automatic plan_step(input bit [14:0] h);
    exp_t e;
    bit   hh;
    e      = cur;
    e.busy = 1'b1;
    hh     = mhit;
    if (body.size() == mlen) begin
      e.plot         = 1'b1;
      {e.x, e.y}     = body.pop_front();
      e.c            = BG;
      e.hit          = hh;
      sched.push_back(e);
    end
    e.plot = 1'b0;
    foreach (body[i]) begin
      e.hit = hh;
      sched.push_back(e);
      if (body[i] == h) hh = 1'b1;
    end
    e.plot     = 1'b1;
    {e.x, e.y} = h;
    e.c        = BODY;
    e.hit      = hh;
    sched.push_back(e);
    body.push_back(h);
    mhit = hh;
  endtask

  always @(posedge clk) begin
    if (!resetn) begin
      body.delete();
      sched.delete();
      mlen        = INIT_LEN;
      mhit        = 1'b0;
      cur         = '{plot: 1'b0, x: 8'd0, y: 7'd0, c: 3'd0, busy: 1'b0, hit: 1'b0, len: INIT_LEN};
      model_valid = 1'b1;
    end else if (model_valid) begin
      if (step && !cur.busy) plan_step({head_x, head_y});
      if (sched.size() > 0) begin
        cur = sched.pop_front();
      end else begin
        cur.plot = 1'b0;
        cur.busy = 1'b0;
        cur.hit  = mhit;
      end
      if (grow && mlen < MAX_LEN) mlen++;
      cur.len = mlen;
    end
  end

  bit [17:0] plot_log[$];
  int        busy_cnt;

  always @(negedge clk) begin
    if (model_valid) begin
      check("vga_plot",   vga_plot,   cur.plot);
      check("busy",       busy,       cur.busy);
      check("self_hit",   self_hit,   cur.hit);
      check("length",     length,     cur.len);
      check("vga_x",      vga_x,      cur.x);
      check("vga_y",      vga_y,      cur.y);
      check("vga_colour", vga_colour, cur.c);
      if (vga_plot) plot_log.push_back({vga_x, vga_y, vga_colour});
      if (busy) busy_cnt++;
    end
  end

  function automatic bit [17:0] pk(input bit [7:0] x, input bit [6:0] y, input bit [2:0] c);
    return {x, y, c};
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", busy, 1'b0);
  endtask

  task automatic do_step(input bit [7:0] x, input bit [6:0] y, input bit g);
    @(negedge clk);
    plot_log.delete();
    busy_cnt = 0;
    step   = 1'b1;
    grow   = g;
    head_x = x;
    head_y = y;
    @(negedge clk);
    step = 1'b0;
    grow = 1'b0;
    wait_idle();
  endtask

  task automatic check_log2(input string name, input bit [17:0] a, input bit [17:0] b);
    check({name, "_plots"}, plot_log.size(), 2);
    if (plot_log.size() == 2) begin
      check({name, "_erase"}, plot_log[0], a);
      check({name, "_draw"},  plot_log[1], b);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_draw;
    resetn = 1'b0;
    step   = 1'b0;
    grow   = 1'b0;
    head_x = '0;
    head_y = '0;
    repeat (2) @(negedge clk);
    check("rst_busy",   busy,     1'b0);
    check("rst_plot",   vga_plot, 1'b0);
    check("rst_length", length,   4'd4);
    check("rst_x",      vga_x,    8'd0);
    resetn = 1'b1;

    // Fill: draw-only steps with a growing scan.
    for (int i = 0; i < 4; i++) begin
      do_step(8'(10 + i), 7'd5, 1'b0);
      check("fill_busy",  busy_cnt, i + 1);
      check("fill_plots", plot_log.size(), 1);
      if (plot_log.size() == 1) check("fill_draw", plot_log[0], pk(8'(10 + i), 7'd5, BODY));
    end
    check("fill_hit", self_hit, 1'b0);

    // Steady move: erase tail, scan 3, draw.
    do_step(8'd14, 7'd5, 1'b0);
    check("steady_busy", busy_cnt, 5);
    check_log2("steady", pk(8'd10, 7'd5, BG), pk(8'd14, 7'd5, BODY));

    // Grow in the same cycle as a step: the erase still happens.
    do_step(8'd15, 7'd5, 1'b1);
    check_log2("grow", pk(8'd11, 7'd5, BG), pk(8'd15, 7'd5, BODY));
    check("grow_length", length, 4'd5);

    do_step(8'd16, 7'd5, 1'b0);
    check("grow2_busy",  busy_cnt, 5);
    check("grow2_plots", plot_log.size(), 1);

    // Self-collision with a body segment.
    do_step(8'd13, 7'd5, 1'b0);
    check_log2("hit", pk(8'd12, 7'd5, BG), pk(8'd13, 7'd5, BODY));
    check("hit_flag", self_hit, 1'b1);

    // Step pulse during SCAN is dropped.
    @(negedge clk);
    plot_log.delete();
    step = 1'b1; head_x = 8'd20; head_y = 7'd5;
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
    check("busy_at_pulse", busy, 1'b1);
    step = 1'b1; head_x = 8'd30; head_y = 7'd6;
    @(negedge clk);
    step = 1'b0;
    wait_idle();
    n_draw = 0;
    foreach (plot_log[i]) if (plot_log[i][2:0] == BODY) n_draw++;
    check("ignored_draws", n_draw, 1);
    check_log2("ignored", pk(8'd13, 7'd5, BG), pk(8'd20, 7'd5, BODY));
    check("hit_sticky", self_hit, 1'b1);

    // Reset in the middle of a scan.
    @(negedge clk);
    step = 1'b1; head_x = 8'd21; head_y = 7'd5;
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
    check("pre_reset_busy", busy, 1'b1);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check("midrst_busy",   busy,     1'b0);
    check("midrst_plot",   vga_plot, 1'b0);
    check("midrst_hit",    self_hit, 1'b0);
    check("midrst_length", length,   4'd4);
    do_step(8'd40, 7'd10, 1'b0);
    check("midrst_busy_cnt", busy_cnt, 1);
    check("midrst_plots",    plot_log.size(), 1);
    if (plot_log.size() == 1) check("midrst_draw", plot_log[0], pk(8'd40, 7'd10, BODY));

    // Growth saturates at MAX_LEN.
    @(negedge clk);
    grow = 1'b1;
    repeat (10) @(negedge clk);
    grow = 1'b0;
    check("saturate_length", length, 4'd8);

    // Random traffic on a small grid so collisions are frequent.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      step   = ($urandom_range(0, 2) == 0);
      grow   = ($urandom_range(0, 15) == 0);
      head_x = 8'($urandom_range(0, 3));
      head_y = 7'($urandom_range(0, 3));
      resetn = ($urandom_range(0, 299) != 0);
    end
    @(negedge clk);
    step   = 1'b0;
    grow   = 1'b0;
    resetn = 1'b1;
    repeat (20) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/snake_body_renderer.md
Name: snake_body_renderer

Overview:
- Sits between snake_datapath (head position producer) and the VGA adapter write port.
- Records every head position in a circular history buffer and draws each new head pixel.
- Once the snake reaches its current length, reads back the oldest position on each step and erases it.
- Scans the remaining body against the new head to flag self-collision.

Parameters:
- MAX_LEN, 8, history buffer depth and maximum snake length; must be a power of two so pointers wrap naturally.
- INIT_LEN, 4, snake length after reset; 1 <= INIT_LEN <= MAX_LEN.
- BODY_COLOUR, 3'b010, colour written for the head pixel.
- BG_COLOUR, 3'b000, colour written for an erased tail pixel.

Ports:
- clk  input  1  system clock.
- resetn  input  1  synchronous active-low reset.
- step  input  1  one-cycle pulse: head has moved to head_x/head_y.
- head_x  input  8  new head x.
- head_y  input  7  new head y.
- grow  input  1  one-cycle pulse: increase target length by one.
- vga_x  output  8  pixel x to VGA adapter.
- vga_y  output  7  pixel y to VGA adapter.
- vga_colour  output  3  pixel colour.
- vga_plot  output  1  VGA write enable.
- busy  output  1  high while not IDLE; step is ignored while high.
- self_hit  output  1  sticky self-collision flag.
- length  output  $clog2(MAX_LEN+1)  current target length.

Behaviour:
- Single clock domain. Reset is synchronous and active-low: clk and resetn.
- Reset state:
  - state IDLE; buffer count = 0; rd_ptr = wr_ptr = 0.
  - length = INIT_LEN; self_hit = 0.
  - vga_plot = 0, vga_x = 0, vga_y = 0, vga_colour = 0, busy = 0.
- Reset mid-operation aborts the current step immediately; the buffer is emptied and no further plot occurs.
- States: IDLE, ERASE, SCAN, DRAW.
- IDLE:
  - On step, latch head_x/head_y into hx/hy.
  - If count == length, go to ERASE. Else if count > 0, go to SCAN. Else go to DRAW.
- ERASE (1 cycle):
  - vga_plot = 1; vga_x/vga_y = mem[rd_ptr]; vga_colour = BG_COLOUR.
  - rd_ptr++ (mod MAX_LEN); count--.
  - Next state is SCAN if the new count > 0, else DRAW.
- SCAN (exactly count cycles, one entry per cycle, oldest first):
  - Compare mem[(rd_ptr + i) mod MAX_LEN] against hx/hy.
  - On an exact match of both coordinates, set self_hit = 1.
  - vga_plot = 0 throughout.
  - After the last entry, go to DRAW.
- DRAW (1 cycle):
  - vga_plot = 1; vga_x = hx; vga_y = hy; vga_colour = BODY_COLOUR.
  - mem[wr_ptr] <= {hx, hy}; wr_ptr++; count++.
  - Return to IDLE.
- vga_* are Moore outputs of registered state. vga_x, vga_y and vga_colour hold their last values when vga_plot = 0.
- Latency: a step accepted at edge T makes busy high from T+1. Busy lasts (erase ? 1 : 0) + scan_count + 1 cycles, where scan_count is count after any erase.
- step while busy: ignored, not queued.
- grow:
  - Accepted in any state; length increments at that edge, saturating at MAX_LEN.
  - grow at MAX_LEN is ignored.
  - grow and step in the same IDLE cycle: the erase decision uses the pre-increment length.
- self_hit stays set until reset. Movement and plotting continue after a hit; game-over policy belongs elsewhere.
- count never exceeds length, and length never exceeds MAX_LEN.
- No coordinate range checking: values pass through unchanged.

Test Plan (MAX_LEN = 8, INIT_LEN = 4):
- Fill:
  - Stimulus: reset, then steps at (10,5), (11,5), (12,5), (13,5), each spaced until busy = 0.
  - Response: no erase; exactly one green plot per step, at that head position; busy cycles per step = 1, 2, 3, 4; count ends at 4; self_hit = 0.
- Steady move:
  - Stimulus: step at (14,5).
  - Response: plot (10,5) colour 000; then 3 SCAN cycles with plot = 0; then plot (14,5) colour 010; busy high 5 cycles.
- Grow:
  - Stimulus: grow and step at (15,5) in the same cycle.
  - Response: erase (11,5) (pre-increment length 4 is used); draw (15,5); length = 5, count = 4.
  - Stimulus: next step at (16,5).
  - Response: no erase; count = 5.
- Self-collision:
  - Stimulus: after the Grow scenario, step at (13,5).
  - Response: erase (12,5); scan finds (13,5); self_hit = 1 before DRAW and stays 1 through later steps.
- Busy / saturate:
  - Stimulus: pulse step during SCAN.
  - Response: ignored; exactly one DRAW occurs.
  - Stimulus: grow x10 from length 4.
  - Response: length = 8.
- Reset mid-op:
  - Stimulus: resetn low during SCAN.
  - Response: next cycle busy = 0, vga_plot = 0, self_hit = 0, length = 4; next step draws with no erase.
